// File: rtl/count_sum_monitor.sv
// Observer for the dual-counter sum: flags and counts wraps (sum decreasing), and raises a
// sticky alarm once q_in has stayed at or above thresh for HOLD consecutive samples.
module count_sum_monitor #(
  parameter int unsigned SIZE   = 10,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   q_in,
  input  logic [SIZE-1:0]   thresh,
  input  logic              clear,
  output logic              above,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              alarm
);

  localparam int unsigned RUN_W = 8;
  localparam int unsigned CMP_W = RUN_W + 1;

  typedef enum logic [1:0] {IDLE, ARMING, ALARM} state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [SIZE-1:0]  q_prev;
  logic             prev_valid;
  logic             hit_c;
  logic             wrap_c;
  logic             run_done_c;

  assign hit_c      = (q_in >= thresh);
  assign wrap_c     = prev_valid & (q_in < q_prev);
  assign run_done_c = ((CMP_W'(run_q) + CMP_W'(1)) == CMP_W'(HOLD));

  // Next-state / run-length logic; clear forces the FSM back to IDLE without looking at q_in.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_c && (HOLD == 1)) begin
            state_d = ALARM;
            run_d   = RUN_W'(1);
          end else if (hit_c) begin
            state_d = ARMING;
            run_d   = RUN_W'(1);
          end else begin
            run_d   = '0;
          end
        end
        ARMING: begin
          if (hit_c && run_done_c) begin
            state_d = ALARM;
            run_d   = run_q + RUN_W'(1);
          end else if (hit_c) begin
            run_d   = run_q + RUN_W'(1);
          end else begin
            state_d = IDLE;
            run_d   = '0;
          end
        end
        ALARM: begin
          state_d = ALARM;
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= '0;
      q_prev     <= '0;
      prev_valid <= 1'b0;
      above      <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      alarm      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      alarm      <= (state_d == ALARM);
      q_prev     <= q_in;
      prev_valid <= 1'b1;
      above      <= hit_c;
      wrap_pulse <= wrap_c;
      // clear beats a simultaneous wrap for the count; the pulse itself still fires.
      if (clear) begin
        wrap_cnt <= '0;
      end else if (wrap_c && (wrap_cnt != {WRAP_W{1'b1}})) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_sum_monitor.sv
// Scoreboard bench for count_sum_monitor: a behavioural model predicts each cycle's outputs,
// plus fixed expectations for the directed scenarios.
module tb_count_sum_monitor;

  localparam int unsigned SIZE   = 10;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned WRAP_W = 8;

  typedef struct packed {
    logic             above;
    logic             wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic             alarm;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SIZE-1:0]   q_in = '0;
  logic [SIZE-1:0]   thresh = '0;
  logic              clear = 1'b0;
  logic              above;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              alarm;

  count_sum_monitor #(.SIZE(SIZE), .HOLD(HOLD), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .thresh(thresh), .clear(clear),
    .above(above), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model state
  int m_mode = 0;   // 0 idle, 1 counting hits, 2 alarmed
  int m_hits = 0;
  int m_prev = 0;
  bit m_pv   = 0;
  int m_wc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict outputs after this edge and advance the model.
  function automatic exp_t model(input bit r, input int q, input int th, input bit clr);
    exp_t e;
    bit   hit;
    bit   wr;
    if (r) begin
      m_mode = 0; m_hits = 0; m_prev = 0; m_pv = 0; m_wc = 0;
      e = '0;
      return e;
    end
    hit = (q >= th);
    wr  = m_pv && (q < m_prev);
    m_prev = q;
    m_pv   = 1;
    if (clr) begin
      m_wc = 0; m_mode = 0; m_hits = 0;
    end else begin
      if (wr && m_wc < (1 << WRAP_W) - 1) m_wc++;
      if (m_mode != 2) begin
        if (hit) begin
          m_hits++;
          m_mode = (m_hits >= HOLD) ? 2 : 1;
        end else begin
          m_hits = 0; m_mode = 0;
        end
      end
    end
    e.above      = hit;
    e.wrap_pulse = wr;
    e.wrap_cnt   = WRAP_W'(m_wc);
    e.alarm      = (m_mode == 2);
    return e;
  endfunction

  // Drive one edge, push the prediction, then pop and compare after the edge.
  task automatic step(input bit r, input int q, input int th, input bit clr);
    exp_t e;
    rst = r; q_in = SIZE'(q); thresh = SIZE'(th); clear = clr;
    sb.push_back(model(r, q, th, clr));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("above", 32'(above), 32'(e.above));
      check("wrap_pulse", 32'(wrap_pulse), 32'(e.wrap_pulse));
      check("wrap_cnt", 32'(wrap_cnt), 32'(e.wrap_cnt));
      check("alarm", 32'(alarm), 32'(e.alarm));
    end
  endtask

  initial begin
    @(negedge clk);

    // 1: reset then a slow ramp below threshold
    step(1, 0, 5, 0);
    step(1, 0, 5, 0);
    check("t1_reset_alarm", 32'(alarm), 32'd0);
    check("t1_reset_wc", 32'(wrap_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, i, 5, 0);
      check("t1_above", 32'(above), 32'd0);
      check("t1_wp", 32'(wrap_pulse), 32'd0);
      check("t1_alarm", 32'(alarm), 32'd0);
    end

    // 2: four hits in a row raise the alarm, which then sticks
    step(1, 0, 5, 0);
    step(0, 5, 5, 0);
    step(0, 6, 5, 0);
    step(0, 7, 5, 0);
    check("t2_alarm_e3", 32'(alarm), 32'd0);
    step(0, 8, 5, 0);
    check("t2_alarm_e4", 32'(alarm), 32'd1);
    step(0, 0, 5, 0);
    check("t2_alarm_sticky", 32'(alarm), 32'd1);
    check("t2_above_drop", 32'(above), 32'd0);

    // 3: a single miss restarts the run
    step(1, 0, 5, 0);
    step(0, 6, 5, 0);
    step(0, 6, 5, 0);
    step(0, 6, 5, 0);
    step(0, 2, 5, 0);
    check("t3_wp_e4", 32'(wrap_pulse), 32'd1);
    step(0, 6, 5, 0);
    check("t3_wp_e5", 32'(wrap_pulse), 32'd0);
    step(0, 6, 5, 0);
    step(0, 6, 5, 0);
    check("t3_alarm_e7", 32'(alarm), 32'd0);
    step(0, 6, 5, 0);
    check("t3_alarm_e8", 32'(alarm), 32'd1);

    // 4: wrap at the top of the range, then saturate the wrap counter
    step(1, 0, 1023, 0);
    step(0, 1022, 1023, 0);
    step(0, 1023, 1023, 0);
    check("t4_wp_1023", 32'(wrap_pulse), 32'd0);
    step(0, 0, 1023, 0);
    check("t4_wp_0", 32'(wrap_pulse), 32'd1);
    check("t4_wc_1", 32'(wrap_cnt), 32'd1);
    step(0, 1, 1023, 0);
    check("t4_wp_1", 32'(wrap_pulse), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, 500, 1023, 0);
      step(0, 100, 1023, 0);
    end
    check("t4_wc_sat", 32'(wrap_cnt), 32'd255);

    // 5: clear on a wrapping edge while alarmed
    for (int i = 0; i < 4; i++) step(0, 900, 5, 0);
    check("t5_alarm_set", 32'(alarm), 32'd1);
    step(0, 3, 5, 1);
    check("t5_alarm_clr", 32'(alarm), 32'd0);
    check("t5_wc_clr", 32'(wrap_cnt), 32'd0);
    check("t5_wp", 32'(wrap_pulse), 32'd1);

    // 6: reset in the middle of a run discards it and suppresses a false wrap
    step(1, 0, 5, 0);
    for (int i = 0; i < 3; i++) step(0, 900, 5, 0);
    step(1, 900, 5, 0);
    step(0, 0, 5, 0);
    check("t6_alarm", 32'(alarm), 32'd0);
    check("t6_wp", 32'(wrap_pulse), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 900, 5, 0);
    check("t6_run_restart", 32'(alarm), 32'd0);
    step(0, 900, 5, 0);
    check("t6_alarm_after4", 32'(alarm), 32'd1);

    // Threshold raised mid-run breaks the run
    step(1, 0, 5, 0);
    step(0, 10, 5, 0);
    step(0, 10, 5, 0);
    step(0, 10, 20, 0);
    check("thr_above", 32'(above), 32'd0);
    step(0, 10, 5, 0);
    step(0, 10, 5, 0);
    step(0, 10, 5, 0);
    check("thr_no_alarm", 32'(alarm), 32'd0);
    step(0, 10, 5, 0);
    check("thr_alarm", 32'(alarm), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 40), $urandom_range(10, 30),
           ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
